// File: rtl/tristate_bus_port_pkg.sv
// Package for tristate_bus_port: FSM state type and counter sizing helper.
// Ports: none.
package tristate_bus_port_pkg;
`include "tristate_bus_port_defs.vh"

  typedef enum logic [1:0] {
    ST_IDLE  = `TBP_ST_IDLE,
    ST_DRIVE = `TBP_ST_DRIVE,
    ST_TURN  = `TBP_ST_TURN
  } state_t;

  // Minimum width able to hold n (at least 1 bit so the counter always exists).
  function automatic int cnt_width(input int n);
    int w;
    w = 1;
    while ((1 << w) <= n) w++;
    return w;
  endfunction
endpackage

// File: rtl/tristate_bus_port_if.sv
// Handshake / status bundle for tristate_bus_port.
// Ports: tx_data, tx_valid (to port); tx_ready, rx_data, rx_valid,
//        drive_active, collision_err (from port).
// slave modport is the port side, master modport is the user side.
interface tristate_bus_port_if #(
  parameter int WIDTH = 8
);
  logic [WIDTH-1:0] tx_data;
  logic             tx_valid;
  logic             tx_ready;
  logic [WIDTH-1:0] rx_data;
  logic             rx_valid;
  logic             drive_active;
  logic             collision_err;

  modport slave (
    input  tx_data, tx_valid,
    output tx_ready, rx_data, rx_valid, drive_active, collision_err
  );

  modport master (
    output tx_data, tx_valid,
    input  tx_ready, rx_data, rx_valid, drive_active, collision_err
  );
endinterface

// File: rtl/tristate_bus_driver.sv
// Combinational tristate output stage: out = en ? in : all-Z.
// Ports: en (output enable), in (word to drive), out (tristate bus).
module tristate_bus_driver #(
  parameter int WIDTH = 8
) (
  input  logic             en,
  input  logic [WIDTH-1:0] in,
  output wire  [WIDTH-1:0] out
);
  assign out = en ? in : {WIDTH{1'bz}};
endmodule

// File: rtl/tristate_bus_port_defs.vh
// Shared state encodings for tristate_bus_port.
// Included by the RTL package and by the testbench, so both agree on the
// encoding when probing or decoding the FSM state.
`ifndef TRISTATE_BUS_PORT_DEFS_VH
`define TRISTATE_BUS_PORT_DEFS_VH

`define TBP_ST_IDLE  2'd0
`define TBP_ST_DRIVE 2'd1
`define TBP_ST_TURN  2'd2

`endif

// File: rtl/tristate_bus_port.sv
// Tristate bus port: drives accepted words onto a shared bus, inserts an
// idle turnaround after each burst, and samples the bus while released.
// Ports: clk, rst_n (async active-low), bus (shared tristate bus),
//        port (tristate_bus_port_if.slave: tx/rx handshake and status).
// Optional build macro: TRISTATE_BUS_PORT_COLLISION_EN adds a sticky
// drive-mismatch detector on collision_err; otherwise it is tied to 0.
//
// state | meaning
// IDLE  | bus released, sampling bus into rx_data every cycle
// DRIVE | out_q on bus, further words accepted back to back
// TURN  | bus released, tx blocked until the turnaround count expires
module tristate_bus_port
  import tristate_bus_port_pkg::*;
#(
  parameter int WIDTH       = 8,
  parameter int TURN_CYCLES = 1
) (
  input  logic             clk,
  input  logic             rst_n,
  inout  wire  [WIDTH-1:0] bus,
  tristate_bus_port_if.slave port
);
  localparam int             CW        = cnt_width(TURN_CYCLES);
  localparam logic [CW-1:0]  TURN_LOAD = CW'(TURN_CYCLES);

  state_t           state_q;
  logic             oe_q;
  logic [WIDTH-1:0] out_q;
  logic [CW-1:0]    cnt_q;
  logic [WIDTH-1:0] rx_data_q;
  logic             rx_valid_q;
  logic             accept;

  assign port.tx_ready     = (state_q != ST_TURN);
  assign accept            = port.tx_valid && port.tx_ready;
  assign port.drive_active = oe_q;
  assign port.rx_data      = rx_data_q;
  assign port.rx_valid     = rx_valid_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= ST_IDLE;
      oe_q       <= 1'b0;
      out_q      <= '0;
      cnt_q      <= '0;
      rx_data_q  <= '0;
      rx_valid_q <= 1'b0;
    end else begin
      if (state_q == ST_IDLE && !oe_q) begin
        rx_data_q  <= bus;
        rx_valid_q <= 1'b1;
      end else begin
        rx_valid_q <= 1'b0;
      end

      case (state_q)
        ST_IDLE: begin
          if (accept) begin
            out_q   <= port.tx_data;
            oe_q    <= 1'b1;
            state_q <= ST_DRIVE;
          end
        end
        ST_DRIVE: begin
          if (accept) begin
            out_q <= port.tx_data;
            oe_q  <= 1'b1;
          end else begin
            oe_q <= 1'b0;
            if (TURN_CYCLES == 0) begin
              state_q <= ST_IDLE;
            end else begin
              state_q <= ST_TURN;
              cnt_q   <= TURN_LOAD;
            end
          end
        end
        ST_TURN: begin
          // Leaving on count 1 (or a stray 0) keeps the counter from wrapping.
          if (cnt_q <= CW'(1)) begin
            cnt_q   <= '0;
            state_q <= ST_IDLE;
          end else begin
            cnt_q <= cnt_q - CW'(1);
          end
        end
        default: begin
          oe_q    <= 1'b0;
          state_q <= ST_IDLE;
        end
      endcase
    end
  end

  tristate_bus_driver #(.WIDTH(WIDTH)) u_drv (
    .en  (oe_q),
    .in  (out_q),
    .out (bus)
  );

`ifdef TRISTATE_BUS_PORT_COLLISION_EN
  logic coll_q;

  // Case inequality so an X or Z readback also counts as a collision.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      coll_q <= 1'b0;
    end else if (state_q == ST_IDLE && accept) begin
      coll_q <= 1'b0;
    end else if (oe_q && (bus !== out_q)) begin
      coll_q <= 1'b1;
    end
  end

  assign port.collision_err = coll_q;
`else
  assign port.collision_err = 1'b0;
`endif
endmodule

// File: tb/tb_tristate_bus_port.sv
`include "tristate_bus_port_defs.vh"

module tb_tristate_bus_port;
  int n_cmp = 0;
  int n_bad = 0;

  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;

  // DUT A: 8-bit, two turnaround cycles
  tristate_bus_port_if #(.WIDTH(8)) ifa ();
  wire  [7:0] bus_a;
  logic       ext_en_a;
  logic [7:0] ext_a;
  assign bus_a = ext_en_a ? ext_a : 8'hzz;

  tristate_bus_port #(.WIDTH(8), .TURN_CYCLES(2)) dut_a (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus_a),
    .port  (ifa.slave)
  );

  // DUT B: 16-bit, no turnaround
  tristate_bus_port_if #(.WIDTH(16)) ifb ();
  wire  [15:0] bus_b;
  logic        ext_en_b;
  logic [15:0] ext_b;
  assign bus_b = ext_en_b ? ext_b : 16'hzzzz;

  tristate_bus_port #(.WIDTH(16), .TURN_CYCLES(0)) dut_b (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus_b),
    .port  (ifb.slave)
  );

  logic [7:0]  exp_bus_a[$];
  logic [7:0]  exp_rx_a[$];
  logic [15:0] exp_bus_b[$];

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    logic [7:0] got;
    rst_n = 1'b0;
    ifa.tx_valid = 1'b0; ifa.tx_data = '0;
    ifb.tx_valid = 1'b0; ifb.tx_data = '0;
    ext_en_a = 1'b0; ext_a = '0;
    ext_en_b = 1'b0; ext_b = '0;
    #22;
    n_cmp++; if (ifa.drive_active !== 1'b0) begin n_bad++; $display("FAIL reset_oe_a got=%b exp=0", ifa.drive_active); end
    n_cmp++; if (ifa.tx_ready !== 1'b1) begin n_bad++; $display("FAIL reset_ready_a got=%b exp=1", ifa.tx_ready); end
    n_cmp++; if (ifa.rx_valid !== 1'b0) begin n_bad++; $display("FAIL reset_rxv_a got=%b exp=0", ifa.rx_valid); end
    got = ifa.rx_data;
    n_cmp++; if (got !== 8'h00) begin n_bad++; $display("FAIL reset_rxd_a got=%h exp=00", got); end
    n_cmp++; if (ifa.collision_err !== 1'b0) begin n_bad++; $display("FAIL reset_coll_a got=%b exp=0", ifa.collision_err); end
    n_cmp++; if (dut_a.state_q !== `TBP_ST_IDLE) begin n_bad++; $display("FAIL reset_state_a got=%0d exp=%0d", dut_a.state_q, `TBP_ST_IDLE); end
    n_cmp++; if (ifb.drive_active !== 1'b0) begin n_bad++; $display("FAIL reset_oe_b got=%b exp=0", ifb.drive_active); end
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  task automatic test_rx_sample();
    ext_a = 8'hA5; ext_en_a = 1'b1;
    exp_rx_a.push_back(8'hA5);
    tick();
    n_cmp++; if (bus_a !== 8'hA5) begin n_bad++; $display("FAIL rx_bus got=%h exp=a5", bus_a); end
    n_cmp++; if (ifa.drive_active !== 1'b0) begin n_bad++; $display("FAIL rx_oe got=%b exp=0", ifa.drive_active); end
    n_cmp++; if (ifa.rx_valid !== 1'b1) begin n_bad++; $display("FAIL rx_valid got=%b exp=1", ifa.rx_valid); end
    if (exp_rx_a.size() == 0) begin n_cmp++; n_bad++; $display("FAIL rx_data got=%h exp=<empty queue>", ifa.rx_data); end
    else begin
      logic [7:0] e;
      e = exp_rx_a.pop_front();
      n_cmp++; if (ifa.rx_data !== e) begin n_bad++; $display("FAIL rx_data got=%h exp=%h", ifa.rx_data, e); end
    end
    ext_en_a = 1'b0;
  endtask

  task automatic test_back_to_back();
    logic [7:0] words[3];
    logic [7:0] e;
    words[0] = 8'h11; words[1] = 8'h22; words[2] = 8'h33;
    for (int i = 0; i < 3; i++) begin
      ifa.tx_data = words[i]; ifa.tx_valid = 1'b1;
      n_cmp++; if (ifa.tx_ready !== 1'b1) begin n_bad++; $display("FAIL b2b_ready[%0d] got=%b exp=1", i, ifa.tx_ready); end
      exp_bus_a.push_back(words[i]);
      tick();
      n_cmp++; if (ifa.drive_active !== 1'b1) begin n_bad++; $display("FAIL b2b_oe[%0d] got=%b exp=1", i, ifa.drive_active); end
      e = exp_bus_a.pop_front();
      n_cmp++; if (bus_a !== e) begin n_bad++; $display("FAIL b2b_bus[%0d] got=%h exp=%h", i, bus_a, e); end
      if (i > 0) begin
        n_cmp++; if (ifa.rx_valid !== 1'b0) begin n_bad++; $display("FAIL b2b_rxv[%0d] got=%b exp=0", i, ifa.rx_valid); end
      end
    end
  endtask

  task automatic test_turnaround();
    int low_cycles;
    int guard;
    logic [7:0] e;
    ifa.tx_valid = 1'b0;
    tick();
    n_cmp++; if (ifa.drive_active !== 1'b0) begin n_bad++; $display("FAIL turn_oe got=%b exp=0", ifa.drive_active); end
    n_cmp++; if (dut_a.state_q !== `TBP_ST_TURN) begin n_bad++; $display("FAIL turn_state got=%0d exp=%0d", dut_a.state_q, `TBP_ST_TURN); end
    ifa.tx_data = 8'h77; ifa.tx_valid = 1'b1;
    low_cycles = 0;
    guard = 0;
    while (ifa.tx_ready === 1'b0 && guard < 10) begin
      low_cycles++;
      guard++;
      tick();
      n_cmp++; if (ifa.drive_active !== 1'b0) begin n_bad++; $display("FAIL turn_held_oe got=%b exp=0", ifa.drive_active); end
    end
    n_cmp++; if (low_cycles != 2) begin n_bad++; $display("FAIL turn_ready_low got=%0d exp=2", low_cycles); end
    exp_bus_a.push_back(8'h77);
    tick();
    n_cmp++; if (ifa.drive_active !== 1'b1) begin n_bad++; $display("FAIL turn_accept_oe got=%b exp=1", ifa.drive_active); end
    e = exp_bus_a.pop_front();
    n_cmp++; if (bus_a !== e) begin n_bad++; $display("FAIL turn_accept_bus got=%h exp=%h", bus_a, e); end
    ifa.tx_valid = 1'b0;
    guard = 0;
    tick();
    while (dut_a.state_q !== `TBP_ST_IDLE && guard < 10) begin guard++; tick(); end
    n_cmp++; if (guard >= 10) begin n_bad++; $display("FAIL turn_drain got=timeout exp=idle"); end
  endtask

  task automatic test_turn0_wide();
    logic [15:0] e;
    ifb.tx_data = 16'hBEEF; ifb.tx_valid = 1'b1;
    exp_bus_b.push_back(16'hBEEF);
    tick();
    ifb.tx_valid = 1'b0;
    e = exp_bus_b.pop_front();
    n_cmp++; if (bus_b !== e) begin n_bad++; $display("FAIL w16_bus got=%h exp=%h", bus_b, e); end
    n_cmp++; if (ifb.drive_active !== 1'b1) begin n_bad++; $display("FAIL w16_oe got=%b exp=1", ifb.drive_active); end
    tick();
    n_cmp++; if (dut_b.state_q !== `TBP_ST_IDLE) begin n_bad++; $display("FAIL w16_state got=%0d exp=%0d", dut_b.state_q, `TBP_ST_IDLE); end
    n_cmp++; if (ifb.tx_ready !== 1'b1) begin n_bad++; $display("FAIL w16_ready got=%b exp=1", ifb.tx_ready); end
    n_cmp++; if (ifb.drive_active !== 1'b0) begin n_bad++; $display("FAIL w16_oe_off got=%b exp=0", ifb.drive_active); end
    ext_b = 16'h1234; ext_en_b = 1'b1;
    tick();
    n_cmp++; if (ifb.rx_valid !== 1'b1 || ifb.rx_data !== 16'h1234) begin
      n_bad++; $display("FAIL w16_rx got=%b/%h exp=1/1234", ifb.rx_valid, ifb.rx_data);
    end
    ext_en_b = 1'b0;
  endtask

  task automatic test_async_reset();
    logic [7:0] e;
    ifa.tx_data = 8'h5A; ifa.tx_valid = 1'b1;
    exp_bus_a.push_back(8'h5A);
    tick();
    e = exp_bus_a.pop_front();
    n_cmp++; if (bus_a !== e) begin n_bad++; $display("FAIL arst_pre_bus got=%h exp=%h", bus_a, e); end
    #2;
    rst_n = 1'b0;
    ext_a = 8'h3C; ext_en_a = 1'b1;
    #1;
    n_cmp++; if (ifa.drive_active !== 1'b0) begin n_bad++; $display("FAIL arst_oe got=%b exp=0", ifa.drive_active); end
    n_cmp++; if (bus_a !== 8'h3C) begin n_bad++; $display("FAIL arst_bus got=%h exp=3c", bus_a); end
    n_cmp++; if (dut_a.state_q !== `TBP_ST_IDLE) begin n_bad++; $display("FAIL arst_state got=%0d exp=%0d", dut_a.state_q, `TBP_ST_IDLE); end
    n_cmp++; if (ifa.rx_valid !== 1'b0) begin n_bad++; $display("FAIL arst_rxv got=%b exp=0", ifa.rx_valid); end
    ifa.tx_valid = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    ext_en_a = 1'b0;
  endtask

  task automatic test_collision();
    logic exp_coll;
`ifdef TRISTATE_BUS_PORT_COLLISION_EN
    exp_coll = 1'b1;
`else
    exp_coll = 1'b0;
`endif
    tick();
    ifa.tx_data = 8'hFF; ifa.tx_valid = 1'b1;
    ext_a = 8'h00; ext_en_a = 1'b1;
    tick();
    ifa.tx_valid = 1'b0;
    tick();
    n_cmp++; if (ifa.collision_err !== exp_coll) begin n_bad++; $display("FAIL coll_set got=%b exp=%b", ifa.collision_err, exp_coll); end
    ext_en_a = 1'b0;
    for (int i = 0; i < 3; i++) tick();
    n_cmp++; if (ifa.collision_err !== exp_coll) begin n_bad++; $display("FAIL coll_sticky got=%b exp=%b", ifa.collision_err, exp_coll); end
    ifa.tx_data = 8'h42; ifa.tx_valid = 1'b1;
    tick();
    ifa.tx_valid = 1'b0;
    n_cmp++; if (ifa.collision_err !== 1'b0) begin n_bad++; $display("FAIL coll_clear got=%b exp=0", ifa.collision_err); end
    for (int i = 0; i < 4; i++) tick();
  endtask

  initial begin
    test_reset();
    test_rx_sample();
    test_back_to_back();
    test_turnaround();
    test_turn0_wide();
    test_async_reset();
    test_collision();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
